display_scan_ctrl: RTL and testbench

//  Time-multiplexed scan driver for the 4-digit seven-segment display.

---
 rtl/seg_disp_pkg.sv | 33 +++
 rtl/tick_divider.sv | 28 ++
 rtl/display_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// Shared types and helpers for the seven-segment scan driver.
package seg_disp_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef logic [1:0] digit_idx_t;

    // Bit k set means digit k (0 = leftmost) is a leading zero to blank.
    // The rightmost digit is never blanked so a zero value still shows "0".
    function automatic logic [3:0] lz_mask(input logic [15:0] word);
        logic [3:0] mask;
        mask[0] = (word[15:12] == 4'h0);
        mask[1] = mask[0] && (word[11:8] == 4'h0);
        mask[2] = mask[1] && (word[7:4] == 4'h0);
        mask[3] = 1'b0;
        return mask;
    endfunction

    // Nibble of the word shown on digit idx (idx 0 = bits [15:12]).
    function automatic logic [3:0] digit_nibble(input logic [15:0] word, input digit_idx_t idx);
        logic [3:0] nib;
        case (idx)
            2'd0:    nib = word[15:12];
            2'd1:    nib = word[11:8];
            2'd2:    nib = word[7:4];
            2'd3:    nib = word[3:0];
            default: nib = BLANK_CODE;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter producing a one-cycle tick on its last count.
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick_o = (cnt_q == LAST);

    // Count 0..DIV-1 and wrap back to zero on the tick cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
        end else if (cnt_q == LAST) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan driver: steps a digit index at the refresh
// rate, double-buffers the BCD word so frames never tear, and applies
// leading-zero blanking and blinking on the registered num/enable outputs.
module display_scan_ctrl
    import seg_disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd_in,
    input  logic        bcd_valid,
    output logic        bcd_ready,
    input  logic        blank_lz,
    input  logic        blink_en,
    output logic [3:0]  num,
    output logic [1:0]  enable,
    output logic        frame_tick
);

    localparam int             BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam digit_idx_t     LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

    logic          slot_tick_s;
    logic          fb_s;
    logic          xfer_s;
    digit_idx_t    idx_q;
    digit_idx_t    idx_next_s;
    logic [15:0]   disp_q;
    logic [15:0]   disp_d;
    logic [15:0]   pend_q;
    logic          pend_full_q;
    logic [BW-1:0] blink_cnt_q;
    logic [BW-1:0] blink_cnt_d;
    logic          phase_q;
    logic          phase_d;
    logic [3:0]    lz_mask_s;
    logic [3:0]    num_d;
    logic [3:0]    num_q;
    logic [1:0]    enable_q;
    logic          frame_tick_q;

    tick_divider #(.DIV(REFRESH_DIV)) u_slot_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (slot_tick_s)
    );

    assign fb_s       = slot_tick_s && (idx_q == LAST_DIGIT);
    assign xfer_s     = bcd_valid && !pend_full_q;
    assign bcd_ready  = !pend_full_q;
    assign idx_next_s = idx_q + 2'd1;
    assign num        = num_q;
    assign enable     = enable_q;
    assign frame_tick = frame_tick_q;

    // Next display word, blink phase and the digit to show after this slot;
    // the first digit of a new frame already sees the new word and phase.
    always_comb begin
        disp_d      = disp_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (fb_s && pend_full_q) begin
            disp_d = pend_q;
        end else begin
            disp_d = disp_q;
        end
        if (fb_s) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = {BW{1'b0}};
                phase_d     = !phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
                phase_d     = phase_q;
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
            phase_d     = phase_q;
        end
        lz_mask_s = lz_mask(disp_d);
        if (blink_en && phase_d) begin
            num_d = BLANK_CODE;
        end else if (blank_lz && lz_mask_s[idx_next_s]) begin
            num_d = BLANK_CODE;
        end else begin
            num_d = digit_nibble(disp_d, idx_next_s);
        end
    end

    // Pending/display double buffer: loads land in pend, promoted only at a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= 16'h0000;
            pend_full_q <= 1'b0;
            disp_q      <= 16'hFFFF;
        end else if (xfer_s) begin
            pend_q      <= bcd_in;
            pend_full_q <= 1'b1;
        end else if (fb_s && pend_full_q) begin
            disp_q      <= disp_d;
            pend_full_q <= 1'b0;
        end else begin
            pend_full_q <= pend_full_q;
        end
    end

    // Blink frame counter runs on every frame boundary regardless of blink_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= {BW{1'b0}};
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    // Digit index and registered scan outputs, advanced once per slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= 2'd0;
            num_q        <= BLANK_CODE;
            enable_q     <= 2'd0;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= fb_s;
            if (slot_tick_s) begin
                idx_q    <= idx_next_s;
                enable_q <= idx_next_s;
                num_q    <= num_d;
            end else begin
                idx_q    <= idx_q;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with a cycle-count based reference model.
module tb_display_scan_ctrl;

    localparam int DIV = 4;
    localparam int BF  = 2;

    typedef struct {
        logic [1:0] en;
        logic [3:0] num;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] bcd_in = 16'h0000;
    logic        bcd_valid = 1'b0;
    logic        bcd_ready;
    logic        blank_lz = 1'b0;
    logic        blink_en = 1'b0;
    logic [3:0]  num;
    logic [1:0]  enable;
    logic        frame_tick;

    int checks = 0;
    int failures = 0;

    display_scan_ctrl #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .bcd_valid  (bcd_valid),
        .bcd_ready  (bcd_ready),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .num        (num),
        .enable     (enable),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    slot_t       exp_q[$];
    int          m_cyc;
    int          m_fb;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_full;
    bit          exp_ready;
    bit          exp_ft;

    function automatic logic [3:0] nib_of(input logic [15:0] w, input int i);
        logic [15:0] t;
        t = w >> (4 * (3 - i));
        return t[3:0];
    endfunction

    function automatic logic [3:0] shown(input logic [15:0] w, input int i,
                                         input bit lz, input bit blank_all);
        bit all_zero;
        if (blank_all) return 4'hF;
        if (lz && i < 3) begin
            all_zero = 1'b1;
            for (int j = 0; j <= i; j++) if (nib_of(w, j) != 4'h0) all_zero = 1'b0;
            if (all_zero) return 4'hF;
        end
        return nib_of(w, i);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_fb = 0; m_disp = 16'hFFFF; m_pend = 16'h0000; m_full = 1'b0;
            exp_ready = 1'b1; exp_ft = 1'b0;
            exp_q.delete();
        end else begin
            int  pos;
            int  cur_digit;
            bit  slot;
            bit  fb;
            bit  xfer;
            slot_t e;
            pos       = m_cyc % DIV;
            cur_digit = (m_cyc / DIV) % 4;
            slot      = (pos == DIV - 1);
            fb        = slot && (cur_digit == 3);
            xfer      = bcd_valid && !m_full;
            if (fb && m_full) begin
                m_disp = m_pend;
                m_full = 1'b0;
            end
            if (xfer) begin
                m_pend = bcd_in;
                m_full = 1'b1;
            end
            if (fb) m_fb++;
            if (slot) begin
                e.en  = 2'((cur_digit + 1) % 4);
                e.num = shown(m_disp, (cur_digit + 1) % 4, blank_lz,
                              blink_en && (((m_fb / BF) % 2) == 1));
                exp_q.push_back(e);
            end
            exp_ft    = fb;
            exp_ready = !m_full;
            m_cyc++;
        end
    end

    // ---------------- monitor ----------------
    logic [1:0] prev_en = 2'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en = 2'd0;
        end else begin
            slot_t e;
            checks++;
            if (bcd_ready !== exp_ready) begin
                failures++;
                $display("FAIL ready t=%0t got=%b exp=%b", $time, bcd_ready, exp_ready);
            end
            checks++;
            if (frame_tick !== exp_ft) begin
                failures++;
                $display("FAIL frame_tick t=%0t got=%b exp=%b", $time, frame_tick, exp_ft);
            end
            if (enable !== prev_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL slot_unexpected t=%0t got en=%0d num=%h exp=none", $time, enable, num);
                end else begin
                    e = exp_q.pop_front();
                    if (enable !== e.en || num !== e.num) begin
                        failures++;
                        $display("FAIL slot t=%0t got en=%0d num=%h exp en=%0d num=%h",
                                 $time, enable, num, e.en, e.num);
                    end
                end
                prev_en = enable;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [15:0] w, input bit keep);
        bit took;
        took      = 1'b0;
        bcd_in    = w;
        bcd_valid = 1'b1;
        for (int n = 0; n < 200 && !took; n++) begin
            took = bcd_ready;
            @(negedge clk);
        end
        checks++;
        if (!took) begin
            failures++;
            $display("FAIL load_timeout word=%h got=not_accepted exp=accepted", w);
        end
        if (!keep) bcd_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (num !== 4'hF || enable !== 2'd0 || frame_tick !== 1'b0 || bcd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s got num=%h en=%0d ft=%b rdy=%b exp num=f en=0 ft=0 rdy=1",
                     tag, num, enable, frame_tick, bcd_ready);
        end
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] msk;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_async");
        idle(3);
        check_reset_outputs("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_release");

        // idle scanning, blank display
        idle(40);
        // simple load mid-frame
        idle(5);
        load(16'h1234, 1'b0);
        idle(40);
        // leading-zero blanking
        blank_lz = 1'b1;
        load(16'h0050, 1'b0); idle(36);
        load(16'h0000, 1'b0); idle(36);
        load(16'h0105, 1'b0); idle(36);
        blank_lz = 1'b0;
        // back-to-back held valid
        load(16'h1111, 1'b1);
        load(16'h2222, 1'b0);
        idle(50);
        // blink
        load(16'h9876, 1'b0);
        idle(20);
        blink_en = 1'b1;
        idle(150);
        idle(2);
        blink_en = 1'b0;
        idle(30);

        // randomized loads and mode changes
        for (int k = 0; k < 30; k++) begin
            w   = 16'($urandom);
            msk = 16'hFFFF >> (4 * $urandom_range(0, 4));
            blank_lz = 1'($urandom_range(0, 1));
            blink_en = ($urandom_range(0, 3) == 0);
            load(w & msk, 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 40));
        end
        bcd_valid = 1'b0;
        blink_en  = 1'b0;
        idle(20);

        // reset mid-frame with a pending word
        load(16'h4321, 1'b0);
        load(16'h5555, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_midframe");
        idle(2);
        rst_n = 1'b1;
        idle(70);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL slots_missing got pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
